// File: rtl/fifo_byte_unpacker_if.sv
// FIFO read port plus outgoing byte stream for the byte unpacker.
// master = the unpacker, slave = the FIFO/consumer side.
interface fifo_byte_unpacker_if #(
  parameter int DATA_W = 16
);
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_data;
  logic              fifo_rd_en;
  logic [7:0]        m_data;
  logic              m_valid;
  logic              m_ready;
  logic              m_last;
  logic              busy;

  modport master (
    input  fifo_empty, fifo_data, m_ready,
    output fifo_rd_en, m_data, m_valid, m_last, busy
  );

  modport slave (
    output fifo_empty, fifo_data, m_ready,
    input  fifo_rd_en, m_data, m_valid, m_last, busy
  );
endinterface

// File: rtl/fifo_byte_unpacker.sv
// Pops one FIFO word at a time and emits it as a valid/ready byte stream,
// flagging the last byte of every FRAME_WORDS-word frame.
module fifo_byte_unpacker #(
  parameter int DATA_W      = 16,
  parameter int FRAME_WORDS = 4,
  parameter int MSB_FIRST   = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  fifo_byte_unpacker_if.master   bus
);
  localparam int BYTES = DATA_W / 8;
  localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int CNT_W = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, SEND} state_t;

  state_t            state;
  logic [DATA_W-1:0] sreg;
  logic [IDX_W-1:0]  byte_idx;
  logic [CNT_W-1:0]  word_cnt;
  logic              last_byte;
  logic              last_word;

  assign last_byte = (byte_idx == IDX_W'(BYTES - 1));
  assign last_word = (word_cnt == CNT_W'(FRAME_WORDS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      sreg     <= '0;
      byte_idx <= '0;
      word_cnt <= '0;
    end else begin
      case (state)
        IDLE: if (!bus.fifo_empty) state <= WAIT;
        WAIT: begin
          // FIFO read data is valid the cycle after the pop strobe
          sreg     <= bus.fifo_data;
          byte_idx <= '0;
          state    <= SEND;
        end
        SEND: if (bus.m_ready) begin
          if (last_byte) begin
            state    <= IDLE;
            word_cnt <= last_word ? '0 : word_cnt + 1'b1;
          end else begin
            byte_idx <= byte_idx + 1'b1;
            // the outgoing byte always sits at a fixed end of the shifter
            sreg     <= (MSB_FIRST != 0) ? (sreg << 8) : (sreg >> 8);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // all outputs decode registered state; fifo_empty only gates the pop in IDLE
  assign bus.fifo_rd_en = (state == IDLE) && !bus.fifo_empty;
  assign bus.m_valid    = (state == SEND);
  assign bus.m_data     = (MSB_FIRST != 0) ? sreg[DATA_W-1 -: 8] : sreg[7:0];
  assign bus.m_last     = (state == SEND) && last_byte && last_word;
  assign bus.busy       = (state != IDLE);
endmodule
